// File: rtl/issue_controller.sv
// issue_controller: fetch/decode/issue sequencer that sits directly upstream
// of the register file. Every register-file strobe is a one-cycle pulse
// produced from the current state and the latched instruction, so the
// register file can sample it cleanly on the following negedge.
module issue_controller #(
    parameter int PC_W     = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [8:0]      instr,
    input  logic            comp,
    input  logic            mem_ready,
    output logic [PC_W-1:0] imem_addr,
    output logic [2:0]      reg_sel,
    output logic            cpyin,
    output logic            cpyout,
    output logic            memLoad,
    output logic            alu_en,
    output logic [1:0]      alu_op,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            halted,
    output logic            mem_err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_CPYIN  = 4'd1;
    localparam logic [3:0] OP_CPYOUT = 4'd2;
    localparam logic [3:0] OP_LOAD   = 4'd3;
    localparam logic [3:0] OP_STORE  = 4'd4;
    localparam logic [3:0] OP_ALU    = 4'd5;
    localparam logic [3:0] OP_CMP    = 4'd6;
    localparam logic [3:0] OP_BRF    = 4'd7;
    localparam logic [3:0] OP_HALT   = 4'd15;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t          state;
    state_t          state_next;
    logic [8:0]      ir;
    logic [PC_W-1:0] pc;
    logic            flag;
    logic [7:0]      wait_cnt;
    logic [3:0]      op;
    logic            is_mem_op;
    logic [PC_W-1:0] branch_off;

    assign op         = ir[8:5];
    assign is_mem_op  = (op == OP_LOAD) || (op == OP_STORE);
    assign branch_off = {{(PC_W-5){ir[4]}}, ir[4:0]};
    assign imem_addr  = pc;

    // State register; reset returns to FETCH regardless of current activity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: three-cycle skeleton plus memory wait and halt.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (is_mem_op) begin
                    state_next = S_MEM_WAIT;
                end else if (op == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready || (wait_cnt == WAIT_LAST)) begin
                    state_next = S_FETCH;
                end
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Datapath registers: instruction latch, PC, branch flag, wait counter, error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir       <= '0;
            reg_sel  <= '0;
            pc       <= '0;
            flag     <= 1'b0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                S_DECODE: begin
                    ir      <= instr;
                    reg_sel <= instr[2:0];
                end
                S_EXEC: begin
                    case (op)
                        OP_CMP: begin
                            flag <= comp;
                            pc   <= pc + 1'b1;
                        end
                        OP_BRF: begin
                            if (flag) begin
                                pc   <= pc + branch_off;
                                flag <= 1'b0;
                            end else begin
                                pc <= pc + 1'b1;
                            end
                        end
                        OP_LOAD, OP_STORE: wait_cnt <= '0;
                        OP_HALT: ;
                        default: pc <= pc + 1'b1;
                    endcase
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        pc <= pc + 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_err <= 1'b1;
                        pc      <= pc + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; register-file strobes are masked while reset is asserted
    // so a reset landing mid-transaction never writes the register file.
    always_comb begin
        cpyin    = 1'b0;
        cpyout   = 1'b0;
        memLoad  = 1'b0;
        alu_en   = 1'b0;
        alu_op   = 2'b00;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = (state == S_HALT);
        case (state)
            S_EXEC: begin
                cpyin    = rst_n && (op == OP_CPYIN);
                cpyout   = rst_n && (op == OP_CPYOUT);
                alu_en   = rst_n && ((op == OP_ALU) || (op == OP_CMP));
                dmem_req = is_mem_op;
                dmem_we  = (op == OP_STORE);
            end
            S_MEM_WAIT: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_STORE);
                memLoad  = rst_n && mem_ready && (op == OP_LOAD);
            end
            default: ;
        endcase
        if (alu_en) begin
            alu_op = ir[4:3];
        end
    end

    logic unused_nop;
    assign unused_nop = (OP_NOP == 4'd0);

endmodule

// File: tb/tb_issue_controller.sv
// tb_issue_controller: drives short programs from a small instruction memory,
// models data memory latency and the ALU compare input, and checks strobes
// against an expected-event scoreboard.
module tb_issue_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] instr;
    logic       comp = 1'b0;
    logic       mem_ready = 1'b0;
    logic [7:0] imem_addr;
    logic [2:0] reg_sel;
    logic       cpyin, cpyout, memLoad, alu_en, dmem_req, dmem_we, halted, mem_err;
    logic [1:0] alu_op;

    issue_controller #(.PC_W(8), .WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .comp(comp), .mem_ready(mem_ready),
        .imem_addr(imem_addr), .reg_sel(reg_sel), .cpyin(cpyin), .cpyout(cpyout),
        .memLoad(memLoad), .alu_en(alu_en), .alu_op(alu_op), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .halted(halted), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] sel;
        logic [1:0] op;
        logic [7:0] cyc;
    } ev_t;

    localparam logic [1:0] K_CPYIN = 2'd0, K_CPYOUT = 2'd1, K_MEMLD = 2'd2, K_ALU = 2'd3;

    ev_t exp_q[$];
    ev_t obs_q[$];

    logic [8:0] imem [256];
    assign instr = imem[imem_addr];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int base = 0;
    int mem_lat = 0;
    int req_cnt = 0;
    int we_cnt = 0;
    logic force_ready = 1'b0;
    logic comp_val = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Data-memory and ALU environment, updated just after each posedge.
    always @(posedge clk) begin
        #1;
        if (dmem_req) begin
            req_cnt = req_cnt + 1;
            if (dmem_we) we_cnt = we_cnt + 1;
        end
        mem_ready = force_ready || (dmem_req && (mem_lat != 0) && (req_cnt == mem_lat));
        comp = alu_en ? comp_val : ~comp_val;
    end

    // Strobe monitor: records pulses and checks mutual exclusivity.
    always @(negedge clk) begin
        int n;
        n = int'(cpyin) + int'(cpyout) + int'(memLoad) + int'(alu_en);
        if (n > 0) begin
            vectors++;
            if (n > 1) begin
                miscompares++;
                $display("[TB] FAIL exclusivity: %0d strobes high, required 1", n);
            end
            if (cpyin)   obs_q.push_back({K_CPYIN,  reg_sel, alu_op, 8'(cyc - base)});
            if (cpyout)  obs_q.push_back({K_CPYOUT, reg_sel, alu_op, 8'(cyc - base)});
            if (memLoad) obs_q.push_back({K_MEMLD,  reg_sel, alu_op, 8'(cyc - base)});
            if (alu_en)  obs_q.push_back({K_ALU,    reg_sel, alu_op, 8'(cyc - base)});
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic load_halts();
        for (int i = 0; i < 256; i++) imem[i] = 9'h1E0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_lat = 0;
        force_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        base = cyc - 1;
        obs_q.delete();
        exp_q.delete();
        req_cnt = 0;
        we_cnt = 0;
    endtask

    task automatic wait_to(input int n);
        do @(negedge clk); while (cyc - base < n);
    endtask

    task automatic test_reset();
        load_halts();
        do_reset();
        wait_to(1);
        vectors++;
        if ({imem_addr, reg_sel, cpyin, cpyout, memLoad, alu_en, alu_op, dmem_req, dmem_we, halted, mem_err} !== 22'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got addr=%h sel=%h strobes=%b%b%b%b req=%b halted=%b err=%b, required all 0",
                     imem_addr, reg_sel, cpyin, cpyout, memLoad, alu_en, dmem_req, halted, mem_err);
        end
    endtask

    task automatic test_copy();
        load_halts();
        imem[0] = 9'h022;
        imem[1] = 9'h045;
        do_reset();
        exp_q.push_back({K_CPYIN, 3'd2, 2'd0, 8'd3});
        exp_q.push_back({K_CPYOUT, 3'd5, 2'd0, 8'd6});
        wait_to(7);
        vectors++;
        if (imem_addr !== 8'h02) begin
            miscompares++;
            $display("[TB] FAIL copy_pc: got %h, required 02", imem_addr);
        end
        wait_to(12);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL copy_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL copy_event: got %h, required %h", o, e);
            end
        end
    endtask

    task automatic test_alu();
        load_halts();
        imem[0] = 9'h0B4;
        imem[1] = 9'h0D8;
        do_reset();
        exp_q.push_back({K_ALU, 3'd4, 2'd2, 8'd3});
        exp_q.push_back({K_ALU, 3'd0, 2'd3, 8'd6});
        wait_to(12);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL alu_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL alu_event: got %h, required %h", o, e);
            end
        end
    endtask

    task automatic test_load();
        load_halts();
        imem[0] = 9'h063;
        do_reset();
        mem_lat = 4;
        exp_q.push_back({K_MEMLD, 3'd3, 2'd0, 8'd6});
        wait_to(7);
        vectors++;
        if (imem_addr !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL load_pc: got %h, required 01", imem_addr);
        end
        wait_to(12);
        vectors++;
        if (req_cnt != 4 || we_cnt != 0 || mem_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_req: got req=%0d we=%0d err=%b, required req=4 we=0 err=0", req_cnt, we_cnt, mem_err);
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL load_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL load_event: got %h, required %h", o, e);
            end
        end
    endtask

    task automatic test_mem_timeout();
        load_halts();
        imem[0] = 9'h085;
        imem[1] = 9'h021;
        do_reset();
        // One request cycle in EXEC plus WAIT_MAX cycles of waiting.
        exp_q.push_back({K_CPYIN, 3'd1, 2'd0, 8'd21});
        wait_to(18);
        vectors++;
        if (mem_err !== 1'b0 || dmem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_pre: got err=%b req=%b, required err=0 req=1", mem_err, dmem_req);
        end
        wait_to(19);
        vectors++;
        if (mem_err !== 1'b1 || dmem_req !== 1'b0 || imem_addr !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL timeout_post: got err=%b req=%b pc=%h, required err=1 req=0 pc=01", mem_err, dmem_req, imem_addr);
        end
        wait_to(30);
        vectors++;
        if (req_cnt != 16 || we_cnt != 16 || mem_err !== 1'b1 || halted !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_sticky: got req=%0d we=%0d err=%b halted=%b, required 16 16 1 1", req_cnt, we_cnt, mem_err, halted);
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL timeout_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL timeout_event: got %h, required %h", o, e);
            end
        end
    endtask

    task automatic test_branch();
        logic [7:0] exp_pc [4];
        int         chk_cyc [4];
        chk_cyc = '{7, 10, 13, 16};
        // Taken branch with wrap, then a second BRF that must see the cleared flag.
        load_halts();
        imem[0] = 9'h000;
        imem[1] = 9'h0C0;
        imem[2] = 9'h0FC;
        imem[8'hFE] = 9'h0FC;
        imem[8'hFF] = 9'h000;
        comp_val = 1'b1;
        do_reset();
        force_ready = 1'b1;
        vectors++;
        if (mem_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL branch_err_reset: got %b, required 0", mem_err);
        end
        exp_pc = '{8'h02, 8'hFE, 8'hFF, 8'h00};
        exp_q.push_back({K_ALU, 3'd0, 2'd0, 8'd6});
        for (int i = 0; i < 4; i++) begin
            wait_to(chk_cyc[i]);
            vectors++;
            if (imem_addr !== exp_pc[i]) begin
                miscompares++;
                $display("[TB] FAIL branch_pc%0d: got %h, required %h", i, imem_addr, exp_pc[i]);
            end
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL branch_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL branch_event: got %h, required %h", o, e);
            end
        end
        // Not taken: comp low only while CMP is computing.
        comp_val = 1'b0;
        do_reset();
        force_ready = 1'b1;
        wait_to(10);
        vectors++;
        if (imem_addr !== 8'h03) begin
            miscompares++;
            $display("[TB] FAIL branch_not_taken: got %h, required 03", imem_addr);
        end
        force_ready = 1'b0;
    endtask

    task automatic test_halt();
        logic [15:0] got;
        load_halts();
        for (int i = 0; i < 5; i++) imem[i] = 9'h000;
        do_reset();
        wait_to(18);
        for (int c = 19; c < 39; c++) begin
            wait_to(c);
            got = {halted, cpyin, cpyout, memLoad, alu_en, dmem_req, dmem_we, 1'b0, imem_addr};
            vectors++;
            if (got !== 16'h8005) begin
                miscompares++;
                $display("[TB] FAIL halt_cycle%0d: got %h, required 8005", c, got);
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL halt_events: got %0d events, required 0", obs_q.size());
        end
        imem[0] = 9'h000;
        do_reset();
        wait_to(1);
        vectors++;
        if (halted !== 1'b0 || imem_addr !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL halt_reset: got halted=%b pc=%h, required 0 00", halted, imem_addr);
        end
        wait_to(4);
        vectors++;
        if (imem_addr !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL halt_restart: got pc=%h, required 01", imem_addr);
        end
    endtask

    task automatic test_reset_mid_load();
        load_halts();
        imem[0] = 9'h063;
        do_reset();
        wait_to(4);
        force_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        force_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({imem_addr, reg_sel, cpyin, cpyout, memLoad, alu_en, alu_op, dmem_req, dmem_we, halted, mem_err} !== 22'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_load: got addr=%h sel=%h req=%b ld=%b, required all 0", imem_addr, reg_sel, dmem_req, memLoad);
        end
        vectors++;
        if (obs_q.size() != 0 || req_cnt != 3) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_load_events: got %0d events req=%0d, required 0 events req=3", obs_q.size(), req_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_alu();
        test_load();
        test_mem_timeout();
        test_branch();
        test_halt();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
